// File: rtl/branch_predictor_btb.sv
// Branch target buffer with per-entry saturating direction counters.
// Lookup is combinational from the current table state. The table learns from
// branches resolved in ID, and the block also flags mispredicts and counts
// resolved branches and mispredicts.
module branch_predictor_btb #(
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2,
  parameter int CNT_W    = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic [31:0]      if_pc,
  output logic             pred_hit,
  output logic             pred_taken,
  output logic [31:0]      pred_npc,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  input  logic             upd_pred_taken,
  input  logic [31:0]      upd_pred_npc,
  output logic             mispredict,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 32 - IDX_W - 2;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);

  // Table storage: one flop set per entry
  logic                valid_reg  [ENTRIES];
  logic [TAG_W-1:0]    tag_reg    [ENTRIES];
  logic [31:0]         target_reg [ENTRIES];
  logic [CTR_BITS-1:0] ctr_reg    [ENTRIES];

  logic [CNT_W-1:0] branch_cnt_reg;
  logic [CNT_W-1:0] mispredict_cnt_reg;

  // Lookup side
  logic [IDX_W-1:0] look_idx;
  logic [TAG_W-1:0] look_tag;

  assign look_idx = if_pc[IDX_W+1:2];
  assign look_tag = if_pc[31:IDX_W+2];

  assign pred_hit   = valid_reg[look_idx] && (tag_reg[look_idx] == look_tag);
  assign pred_taken = pred_hit && ctr_reg[look_idx][CTR_BITS-1];
  assign pred_npc   = pred_taken ? target_reg[look_idx] : (if_pc + 32'd4);

  // Update side
  logic [IDX_W-1:0]    upd_idx;
  logic [TAG_W-1:0]    upd_tag;
  logic                upd_hit;
  logic [CTR_BITS-1:0] upd_ctr;
  logic [CTR_BITS-1:0] ctr_next;
  logic [ENTRIES-1:0]  upd_sel;

  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[31:IDX_W+2];
  assign upd_hit = valid_reg[upd_idx] && (tag_reg[upd_idx] == upd_tag);
  assign upd_ctr = ctr_reg[upd_idx];

  // One-hot select of the entry addressed by the resolved branch
  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_sel
    assign upd_sel[gi] = upd_valid && (upd_idx == IDX_W'(gi));
  end

  // New counter value: saturating step on a hit, weakly taken on allocation
  always_comb begin
    ctr_next = upd_ctr;
    if (!upd_hit) begin
      ctr_next = CTR_WEAK;
    end else if (upd_taken) begin
      if (upd_ctr != CTR_MAX) ctr_next = upd_ctr + 1'b1;
    end else begin
      if (upd_ctr != '0) ctr_next = upd_ctr - 1'b1;
    end
  end

  assign mispredict = upd_valid &&
                      ((upd_pred_taken != upd_taken) ||
                       (upd_taken && (upd_pred_npc != upd_target)));

  // Table update; clear takes priority over a same-cycle update
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_reg[i]  <= 1'b0;
        tag_reg[i]    <= '0;
        target_reg[i] <= '0;
        ctr_reg[i]    <= '0;
      end
    end else if (clear) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_reg[i] <= 1'b0;
        ctr_reg[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (upd_sel[i] && (upd_hit || upd_taken)) begin
          ctr_reg[i] <= ctr_next;
          if (upd_taken) begin
            valid_reg[i]  <= 1'b1;
            tag_reg[i]    <= upd_tag;
            target_reg[i] <= upd_target;
          end
        end
      end
    end
  end

  // Saturating performance counters; they keep counting through clear
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      branch_cnt_reg     <= '0;
      mispredict_cnt_reg <= '0;
    end else begin
      if (upd_valid && (branch_cnt_reg != '1))
        branch_cnt_reg <= branch_cnt_reg + 1'b1;
      if (mispredict && (mispredict_cnt_reg != '1))
        mispredict_cnt_reg <= mispredict_cnt_reg + 1'b1;
    end
  end

  assign branch_cnt     = branch_cnt_reg;
  assign mispredict_cnt = mispredict_cnt_reg;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Self-checking bench for branch_predictor_btb with default parameters.
// Expected lookup results and mispredict flags are queued when stimulus is
// driven and popped when the combinational outputs are sampled.
module tb_branch_predictor_btb;

  logic        clock = 1'b0;
  logic        reset;
  logic        clear;
  logic [31:0] if_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_npc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_npc;
  logic        mispredict;
  logic [31:0] branch_cnt;
  logic [31:0] mispredict_cnt;

  branch_predictor_btb dut (
    .clock          (clock),
    .reset          (reset),
    .clear          (clear),
    .if_pc          (if_pc),
    .pred_hit       (pred_hit),
    .pred_taken     (pred_taken),
    .pred_npc       (pred_npc),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_pred_taken (upd_pred_taken),
    .upd_pred_npc   (upd_pred_npc),
    .mispredict     (mispredict),
    .branch_cnt     (branch_cnt),
    .mispredict_cnt (mispredict_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        hit;
    logic        taken;
    logic [31:0] npc;
  } look_t;

  look_t look_q[$];
  logic  mp_q[$];

  int          n_tests  = 0;
  int          n_fail   = 0;
  logic [31:0] m_branch = 0;
  logic [31:0] m_mp     = 0;

  // Lookup transaction: prediction outputs plus both performance counters
  task automatic lookup(input string nm, input logic [31:0] pc,
                        input logic eh, input logic et, input logic [31:0] en);
    look_t e;
    if_pc   = pc;
    e.hit   = eh;
    e.taken = et;
    e.npc   = en;
    look_q.push_back(e);
    #1;
    e = look_q.pop_front();
    $display("[TB] look %s pc=%h hit=%0b taken=%0b npc=%h bcnt=%0d mcnt=%0d",
             nm, pc, pred_hit, pred_taken, pred_npc, branch_cnt, mispredict_cnt);
    n_tests++;
    if (pred_hit !== e.hit) begin
      n_fail++;
      $display("FAIL %s pred_hit got %0b want %0b", nm, pred_hit, e.hit);
    end
    n_tests++;
    if (pred_taken !== e.taken) begin
      n_fail++;
      $display("FAIL %s pred_taken got %0b want %0b", nm, pred_taken, e.taken);
    end
    n_tests++;
    if (pred_npc !== e.npc) begin
      n_fail++;
      $display("FAIL %s pred_npc got %h want %h", nm, pred_npc, e.npc);
    end
    n_tests++;
    if (branch_cnt !== m_branch) begin
      n_fail++;
      $display("FAIL %s branch_cnt got %0d want %0d", nm, branch_cnt, m_branch);
    end
    n_tests++;
    if (mispredict_cnt !== m_mp) begin
      n_fail++;
      $display("FAIL %s mispredict_cnt got %0d want %0d", nm, mispredict_cnt, m_mp);
    end
  endtask

  // Update transaction: one upd_valid cycle, mispredict checked mid-cycle
  task automatic upd(input string nm, input logic [31:0] pc, input logic tk,
                     input logic [31:0] tgt, input logic ptk, input logic [31:0] pnpc,
                     input logic clr, input logic exp_mp);
    logic e;
    upd_valid      = 1'b1;
    upd_pc         = pc;
    upd_taken      = tk;
    upd_target     = tgt;
    upd_pred_taken = ptk;
    upd_pred_npc   = pnpc;
    clear          = clr;
    mp_q.push_back(exp_mp);
    #1;
    e = mp_q.pop_front();
    $display("[TB] upd  %s pc=%h taken=%0b target=%h clear=%0b mispredict=%0b",
             nm, pc, tk, tgt, clr, mispredict);
    n_tests++;
    if (mispredict !== e) begin
      n_fail++;
      $display("FAIL %s mispredict got %0b want %0b", nm, mispredict, e);
    end
    @(posedge clock);
    #1;
    upd_valid = 1'b0;
    clear     = 1'b0;
    m_branch++;
    if (e) m_mp++;
  endtask

  task automatic test_reset();
    logic e;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    // Update presented while in reset: mispredict still follows the inputs
    upd_valid      = 1'b1;
    upd_pc         = 32'h0040_0010;
    upd_taken      = 1'b1;
    upd_target     = 32'h0040_0040;
    upd_pred_taken = 1'b0;
    upd_pred_npc   = 32'h0040_0014;
    mp_q.push_back(1'b1);
    #1;
    e = mp_q.pop_front();
    $display("[TB] upd  in_reset mispredict=%0b", mispredict);
    n_tests++;
    if (mispredict !== e) begin
      n_fail++;
      $display("FAIL in_reset mispredict got %0b want %0b", mispredict, e);
    end
    @(posedge clock);
    #1;
    upd_valid = 1'b0;
    lookup("reset_low", 32'h0040_0010, 1'b0, 1'b0, 32'h0040_0014);
    reset = 1'b1;
    @(posedge clock);
    #1;
    lookup("after_reset", 32'h0040_0010, 1'b0, 1'b0, 32'h0040_0014);
  endtask

  task automatic test_train();
    upd("alloc", 32'h0040_0010, 1'b1, 32'h0040_0040, 1'b0, 32'h0040_0014, 1'b0, 1'b1);
    lookup("alloc", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0040);
  endtask

  task automatic test_counter();
    upd("nt1", 32'h0040_0010, 1'b0, 32'h0, 1'b1, 32'h0040_0040, 1'b0, 1'b1);
    lookup("ctr1", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0014);
    upd("nt2", 32'h0040_0010, 1'b0, 32'h0, 1'b0, 32'h0040_0014, 1'b0, 1'b0);
    upd("nt3", 32'h0040_0010, 1'b0, 32'h0, 1'b0, 32'h0040_0014, 1'b0, 1'b0);
    lookup("ctr0", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0014);
    upd("t1", 32'h0040_0010, 1'b1, 32'h0040_0040, 1'b0, 32'h0040_0014, 1'b0, 1'b1);
    lookup("ctr_up1", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0014);
    upd("t2", 32'h0040_0010, 1'b1, 32'h0040_0040, 1'b0, 32'h0040_0014, 1'b0, 1'b1);
    lookup("ctr_up2", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0040);
    upd("t3", 32'h0040_0010, 1'b1, 32'h0040_0040, 1'b1, 32'h0040_0040, 1'b0, 1'b0);
    upd("t4", 32'h0040_0010, 1'b1, 32'h0040_0040, 1'b1, 32'h0040_0040, 1'b0, 1'b0);
    lookup("ctr_sat3", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0040);
    // From a saturated 3 one not-taken still predicts taken, a second does not
    upd("nt_top1", 32'h0040_0010, 1'b0, 32'h0, 1'b1, 32'h0040_0040, 1'b0, 1'b1);
    lookup("ctr_top2", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0040);
    upd("nt_top2", 32'h0040_0010, 1'b0, 32'h0, 1'b1, 32'h0040_0040, 1'b0, 1'b1);
    lookup("ctr_top1", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0014);
  endtask

  task automatic test_alias();
    upd("alias", 32'h0040_0050, 1'b1, 32'h0040_0100, 1'b0, 32'h0040_0054, 1'b0, 1'b1);
    lookup("evicted", 32'h0040_0010, 1'b0, 1'b0, 32'h0040_0014);
    lookup("alias_hit", 32'h0040_0050, 1'b1, 1'b1, 32'h0040_0100);
  endtask

  task automatic test_target();
    upd("tgt_wrong", 32'h0040_0010, 1'b1, 32'h0040_0080, 1'b1, 32'h0040_0040, 1'b0, 1'b1);
    lookup("tgt_alloc", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0080);
    lookup("alias_gone", 32'h0040_0050, 1'b0, 1'b0, 32'h0040_0054);
    upd("tgt_match", 32'h0040_0010, 1'b1, 32'h0040_0080, 1'b1, 32'h0040_0080, 1'b0, 1'b0);
    upd("tgt_move", 32'h0040_0010, 1'b1, 32'h0040_0090, 1'b1, 32'h0040_0080, 1'b0, 1'b1);
    lookup("tgt_moved", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0090);
    upd("nt_keep", 32'h0040_0010, 1'b0, 32'hdead_beef, 1'b1, 32'h0040_0090, 1'b0, 1'b1);
    lookup("tgt_kept", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0090);
    upd("miss_nt", 32'h0040_0060, 1'b0, 32'h0, 1'b0, 32'h0040_0064, 1'b0, 1'b0);
    lookup("miss_nt", 32'h0040_0060, 1'b0, 1'b0, 32'h0040_0064);
    upd("idx8", 32'h0040_0020, 1'b1, 32'h0040_0200, 1'b0, 32'h0040_0024, 1'b0, 1'b1);
    lookup("idx8", 32'h0040_0020, 1'b1, 1'b1, 32'h0040_0200);
  endtask

  task automatic test_clear();
    upd("clear", 32'h0040_0030, 1'b1, 32'h0040_0300, 1'b0, 32'h0040_0034, 1'b1, 1'b1);
    lookup("clr_idx4", 32'h0040_0010, 1'b0, 1'b0, 32'h0040_0014);
    lookup("clr_idx8", 32'h0040_0020, 1'b0, 1'b0, 32'h0040_0024);
    lookup("clr_drop", 32'h0040_0030, 1'b0, 1'b0, 32'h0040_0034);
  endtask

  task automatic test_back_to_back();
    look_t e;
    logic  m;
    // Cycle 1: lookup of the index being written returns the old entry
    upd_valid      = 1'b1;
    upd_pc         = 32'h0040_0030;
    upd_taken      = 1'b1;
    upd_target     = 32'h0040_0300;
    upd_pred_taken = 1'b0;
    upd_pred_npc   = 32'h0040_0034;
    if_pc          = 32'h0040_0030;
    e.hit = 1'b0; e.taken = 1'b0; e.npc = 32'h0040_0034;
    look_q.push_back(e);
    mp_q.push_back(1'b1);
    #1;
    e = look_q.pop_front();
    m = mp_q.pop_front();
    $display("[TB] b2b  cycle1 hit=%0b npc=%h mispredict=%0b", pred_hit, pred_npc, mispredict);
    n_tests++;
    if (pred_hit !== e.hit || pred_npc !== e.npc) begin
      n_fail++;
      $display("FAIL b2b_nobypass hit/npc got %0b/%h want %0b/%h", pred_hit, pred_npc, e.hit, e.npc);
    end
    n_tests++;
    if (mispredict !== m) begin
      n_fail++;
      $display("FAIL b2b_mp1 mispredict got %0b want %0b", mispredict, m);
    end
    @(posedge clock);
    #1;
    m_branch++;
    m_mp++;
    // Cycle 2: second update without a gap; first update is now visible
    upd_pc       = 32'h0040_0034;
    upd_target   = 32'h0040_0340;
    upd_pred_npc = 32'h0040_0038;
    e.hit = 1'b1; e.taken = 1'b1; e.npc = 32'h0040_0300;
    look_q.push_back(e);
    mp_q.push_back(1'b1);
    #1;
    e = look_q.pop_front();
    m = mp_q.pop_front();
    $display("[TB] b2b  cycle2 hit=%0b npc=%h mispredict=%0b", pred_hit, pred_npc, mispredict);
    n_tests++;
    if (pred_hit !== e.hit || pred_taken !== e.taken || pred_npc !== e.npc) begin
      n_fail++;
      $display("FAIL b2b_visible hit/taken/npc got %0b/%0b/%h want %0b/%0b/%h",
               pred_hit, pred_taken, pred_npc, e.hit, e.taken, e.npc);
    end
    n_tests++;
    if (mispredict !== m) begin
      n_fail++;
      $display("FAIL b2b_mp2 mispredict got %0b want %0b", mispredict, m);
    end
    @(posedge clock);
    #1;
    upd_valid = 1'b0;
    m_branch++;
    m_mp++;
    lookup("b2b_second", 32'h0040_0034, 1'b1, 1'b1, 32'h0040_0340);
  endtask

  task automatic test_async_reset();
    @(posedge clock);
    #1;
    reset    = 1'b0;
    m_branch = 0;
    m_mp     = 0;
    lookup("arst_30", 32'h0040_0030, 1'b0, 1'b0, 32'h0040_0034);
    lookup("arst_34", 32'h0040_0034, 1'b0, 1'b0, 32'h0040_0038);
    @(posedge clock);
    #1;
    reset = 1'b1;
    upd("post_rst", 32'h0040_0034, 1'b1, 32'h0040_0500, 1'b0, 32'h0040_0038, 1'b0, 1'b1);
    lookup("post_rst", 32'h0040_0034, 1'b1, 1'b1, 32'h0040_0500);
  endtask

  initial begin
    reset          = 1'b0;
    clear          = 1'b0;
    if_pc          = 32'h0;
    upd_valid      = 1'b0;
    upd_pc         = 32'h0;
    upd_taken      = 1'b0;
    upd_target     = 32'h0;
    upd_pred_taken = 1'b0;
    upd_pred_npc   = 32'h0;
    test_reset();
    test_train();
    test_counter();
    test_alias();
    test_target();
    test_clear();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
